// File: rtl/key8_onehot_capture.sv
// key8_onehot_capture
//   Captures the highest-index newly pressed push-button of eight as a one-hot
//   code for a downstream 8-to-3 encoder. The code is held until the consumer
//   acknowledges it. Press events that cannot be captured raise a one-cycle
//   drop pulse.
//
//   Optional feature macro: KEY8_DEBOUNCE_EN
//     defined   : each key is debounced over DEB_CYCLES consecutive cycles
//     undefined : debounced level is the synchronizer output (DEB_CYCLES unused)
//
// Ports
//   iClk    in   1  system clock, rising edge
//   iRst_n  in   1  asynchronous active-low reset
//   iKey    in   8  raw key levels, active-high, asynchronous
//   iAck    in   1  consumer acknowledge of the held code
//   oData   out  8  captured one-hot key code (all-zero when idle)
//   oValid  out  1  oData holds an unacknowledged press
//   oDrop   out  1  one-cycle pulse when a press event is discarded
module key8_onehot_capture #(
  parameter int unsigned DEB_CYCLES = 20
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iKey,
  input  logic       iAck,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oDrop
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e     r_state, w_state_next;
  logic [7:0] r_sync1, r_sync2;
  logic [7:0] w_deb;
  logic [7:0] r_deb_prev;
  logic [7:0] w_evt;
  logic [7:0] w_pick;
  logic       w_multi;
  logic [7:0] r_data, w_data_next;
  logic       r_drop, w_drop_next;

  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb_cycles
    $error("DEB_CYCLES must be in 2..65535");
  end

  // Two-flop synchronizer on every key bit.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= iKey;
      r_sync2 <= r_sync1;
    end
  end

`ifdef KEY8_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEB_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  for (genvar g = 0; g < 8; g++) begin : g_deb
    logic [CntW-1:0] r_cnt;
    logic            r_deb_bit;

    // Counter runs only while the synchronized bit disagrees with the
    // debounced bit; the level flips on the DEB_CYCLES-th mismatching cycle.
    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        r_cnt     <= '0;
        r_deb_bit <= 1'b0;
      end else if (r_sync2[g] == r_deb_bit) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_cnt     <= '0;
        r_deb_bit <= r_sync2[g];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_deb[g] = r_deb_bit;
  end
`else
  assign w_deb = r_sync2;
`endif

  // Previous debounced level, used to find rising (press) edges.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_deb_prev <= '0;
    end else begin
      r_deb_prev <= w_deb;
    end
  end

  assign w_evt   = w_deb & ~r_deb_prev;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multi = |(w_evt & (w_evt - 8'd1));

  // One-hot of the highest-index event; later iterations override earlier.
  always_comb begin
    w_pick = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_evt[i]) begin
        w_pick    = '0;
        w_pick[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_drop  <= w_drop_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_drop_next  = 1'b0;
    case (r_state)
      StIdle: begin
        if (|w_evt) begin
          w_state_next = StHold;
          w_data_next  = w_pick;
          w_drop_next  = w_multi;
        end
      end
      StHold: begin
        // Every press while holding is lost, even one coinciding with iAck.
        w_drop_next = |w_evt;
        if (iAck) begin
          w_state_next = StIdle;
          w_data_next  = '0;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_data_next  = '0;
      end
    endcase
  end

  assign oData  = r_data;
  assign oValid = (r_state == StHold);
  assign oDrop  = r_drop;

endmodule

// File: tb/tb_key8_onehot_capture.sv
module tb_key8_onehot_capture;

  localparam int unsigned Deb = 4;
`ifdef KEY8_DEBOUNCE_EN
  localparam int Lat = 2 + Deb + 1;
  localparam bit Filtered = 1'b1;
`else
  localparam int Lat = 3;
  localparam bit Filtered = 1'b0;
`endif

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic [7:0] iKey;
  logic       iAck;
  logic [7:0] oData;
  logic       oValid;
  logic       oDrop;

  int n_checks = 0;
  int n_errors = 0;

  key8_onehot_capture #(
    .DEB_CYCLES(Deb)
  ) u_dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iKey  (iKey),
    .iAck  (iAck),
    .oData (oData),
    .oValid(oValid),
    .oDrop (oDrop)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic ack_pulse();
    iAck = 1'b1;
    step(1);
    iAck = 1'b0;
  endtask

  logic saw_valid;

  initial begin
    iRst_n = 1'b0;
    iKey   = '0;
    iAck   = 1'b0;
    step(2);
    check("rst_data", oData, 8'h00);
    check("rst_valid", {7'd0, oValid}, 8'h00);
    check("rst_drop", {7'd0, oDrop}, 8'h00);
    iRst_n = 1'b1;
    step(2);

    // Single press: latency and hold until acknowledge.
    iKey = 8'h04;
    step(Lat - 1);
    check("lat_before", {7'd0, oValid}, 8'h00);
    step(1);
    check("lat_valid", {7'd0, oValid}, 8'h01);
    check("lat_data", oData, 8'h04);
    check("lat_drop", {7'd0, oDrop}, 8'h00);
    step(10);
    check("hold_valid", {7'd0, oValid}, 8'h01);
    check("hold_data", oData, 8'h04);
    iKey = 8'h00;
    step(Deb + 6);
    check("release_noevt", oData, 8'h04);
    ack_pulse();
    check("ack_valid", {7'd0, oValid}, 8'h00);
    check("ack_data", oData, 8'h00);

    // Acknowledge while idle is ignored.
    iAck = 1'b1;
    step(2);
    iAck = 1'b0;
    check("idle_ack_valid", {7'd0, oValid}, 8'h00);
    check("idle_ack_drop", {7'd0, oDrop}, 8'h00);

    // Three-cycle glitch on key 3: filtered only when debouncing.
    iKey = 8'h08;
    step(3);
    iKey = 8'h00;
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (oValid || oDrop) saw_valid = 1'b1;
    end
    check("glitch_seen", {7'd0, saw_valid}, {7'd0, !Filtered});
    ack_pulse();
    step(Deb + 6);

    // Simultaneous presses: highest index captured, the rest dropped.
    iKey = 8'h22;
    step(Lat);
    check("multi_valid", {7'd0, oValid}, 8'h01);
    check("multi_data", oData, 8'h20);
    check("multi_drop", {7'd0, oDrop}, 8'h01);
    step(1);
    check("multi_drop_end", {7'd0, oDrop}, 8'h00);
    check("multi_data_keep", oData, 8'h20);
    iKey = 8'h00;
    step(Deb + 6);
    ack_pulse();
    check("multi_ack", oData, 8'h00);

    // Press during hold is dropped; held code unchanged.
    iKey = 8'h01;
    step(Lat);
    check("h0_data", oData, 8'h01);
    iKey = 8'h80;
    step(Lat);
    check("h7_drop", {7'd0, oDrop}, 8'h01);
    check("h7_data", oData, 8'h01);
    step(1);
    check("h7_drop_end", {7'd0, oDrop}, 8'h00);
    ack_pulse();
    check("h7_ack_valid", {7'd0, oValid}, 8'h00);
    check("h7_ack_data", oData, 8'h00);
    step(5);
    check("h7_no_recapture", {7'd0, oValid}, 8'h00);
    iKey = 8'h00;
    step(Deb + 6);

    // Press coinciding with acknowledge is still dropped.
    iKey = 8'h02;
    step(Lat);
    check("coin_hold", oData, 8'h02);
    iKey = 8'h06;
    step(Lat - 1);
    iAck = 1'b1;
    step(1);
    iAck = 1'b0;
    check("coin_drop", {7'd0, oDrop}, 8'h01);
    check("coin_valid", {7'd0, oValid}, 8'h00);
    check("coin_data", oData, 8'h00);
    step(3);
    check("coin_lost", {7'd0, oValid}, 8'h00);
    iKey = 8'h00;
    step(Deb + 6);

    // Asynchronous reset mid-hold, key held through reset.
    iKey = 8'h40;
    step(Lat);
    check("pre_rst_data", oData, 8'h40);
    #2;
    iRst_n = 1'b0;
    #1;
    check("arst_valid", {7'd0, oValid}, 8'h00);
    check("arst_data", oData, 8'h00);
    step(2);
    iRst_n = 1'b1;
    step(Lat - 1);
    check("post_rst_before", {7'd0, oValid}, 8'h00);
    step(1);
    check("post_rst_valid", {7'd0, oValid}, 8'h01);
    check("post_rst_data", oData, 8'h40);
    ack_pulse();
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (oValid) saw_valid = 1'b1;
    end
    check("post_rst_once", {7'd0, saw_valid}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
